// File: rtl/rc_cpl_demux.sv
// RC completion demux: strips the 96-bit descriptor, realigns payload to bit 0 and routes
// each completion to a tag-selected channel. Optional macro RC_ERR_DROP_EN drops errored completions.
module rc_cpl_demux #(
  parameter int DATA_W     = 512,
  parameter int NUM_CH     = 4,
  parameter int CH_SEL_LSB = 5,
  localparam int KEEP_W    = DATA_W / 32
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic              s_axis_rc_tvalid,
  input  logic              s_axis_rc_tlast,
  input  logic [DATA_W-1:0] s_axis_rc_tdata,
  input  logic [KEEP_W-1:0] s_axis_rc_tkeep,
  input  logic [16:0]       s_axis_rc_tuser,
  output logic              s_axis_rc_tready,
  output logic [NUM_CH-1:0] m_axis_tvalid,
  input  logic [NUM_CH-1:0] m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [15:0]       m_axis_tuser,
  output logic [11:0]       m_axis_taddr,
  output logic [15:0]       drop_cnt,
  output logic [1:0]        dbg_state
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW   = DATA_W - 96;
  localparam int RKW  = KEEP_W - 3;

  typedef enum logic [1:0] {S_HDR, S_BODY, S_FLUSH, S_DROP} state_t;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [15:0]       tuser;
    logic [11:0]       taddr;
  } beat_t;

  state_t          state;
  logic            quiet;
  logic [RW-1:0]   res_data;
  logic [RKW-1:0]  res_keep;
  logic [CH_W-1:0] cur_ch;
  logic [15:0]     cur_tuser;
  logic [11:0]     cur_taddr;
  logic            out_valid;
  beat_t           out_q;
  logic            sk_full;
  beat_t           sk_q;

  logic            unused_tuser;
  assign unused_tuser = ^s_axis_rc_tuser;

  // Handshakes: a beat moves on any edge where valid and ready are both high; valid never
  // waits for ready, and a valid beat holds all its fields stable until it is taken.
  logic in_rdy, acc, out_fire, out_free;
  assign in_rdy   = (state == S_DROP) | ((state != S_FLUSH) & ~sk_full);
  assign acc      = s_axis_rc_tvalid & in_rdy;
  assign out_fire = |(m_axis_tvalid & m_axis_tready);
  assign out_free = ~out_valid | out_fire;

  logic [95:0]     desc;
  logic [CH_W-1:0] hdr_ch;
  logic [15:0]     hdr_tuser;
  logic            dc_zero;
  logic            upper_keep;
  assign desc       = s_axis_rc_tdata[95:0];
  assign hdr_ch     = desc[64+CH_SEL_LSB +: CH_W];
  assign hdr_tuser  = {desc[71:64], desc[46:43], desc[15:12]};
  assign dc_zero    = (desc[42:32] == 11'd0);
  assign upper_keep = |s_axis_rc_tkeep[KEEP_W-1:3];

  logic hdr_bad;
  always_comb begin
    hdr_bad = (int'(hdr_ch) >= NUM_CH);
`ifdef RC_ERR_DROP_EN
    hdr_bad = hdr_bad | (desc[45:43] != 3'd0) | (desc[15:12] != 4'd0);
`endif
  end

  logic  gen_v;
  beat_t gen;
  always_comb begin
    gen_v     = 1'b0;
    gen.ch    = cur_ch;
    gen.data  = '0;
    gen.keep  = '0;
    gen.last  = 1'b0;
    gen.tuser = cur_tuser;
    gen.taddr = cur_taddr;
    case (state)
      S_HDR: begin
        gen.ch    = hdr_ch;
        gen.tuser = hdr_tuser;
        gen.taddr = desc[11:0];
        if (acc && !hdr_bad) begin
          if (dc_zero) begin
            gen_v    = 1'b1;
            gen.last = 1'b1;
          end else if (s_axis_rc_tlast) begin
            gen_v    = 1'b1;
            gen.data = {96'b0, s_axis_rc_tdata[DATA_W-1:96]};
            gen.keep = {3'b0, s_axis_rc_tkeep[KEEP_W-1:3]};
            gen.last = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (acc && !quiet) begin
          gen_v    = 1'b1;
          gen.data = {s_axis_rc_tdata[95:0], res_data};
          gen.keep = {s_axis_rc_tkeep[2:0], res_keep};
          gen.last = s_axis_rc_tlast & ~upper_keep;
        end
      end
      S_FLUSH: begin
        if (!sk_full) begin
          gen_v    = 1'b1;
          gen.data = {96'b0, res_data};
          gen.keep = {3'b0, res_keep};
          gen.last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state     <= S_HDR;
      quiet     <= 1'b0;
      res_data  <= '0;
      res_keep  <= '0;
      cur_ch    <= '0;
      cur_tuser <= '0;
      cur_taddr <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      sk_full   <= 1'b0;
      sk_q      <= '0;
      drop_cnt  <= '0;
    end else begin
      // The skid only fills while the output register is stalled, and new beats are
      // held off while it is full, so it drains into the output register first.
      if (out_free) begin
        if (sk_full) begin
          out_q     <= sk_q;
          out_valid <= 1'b1;
          sk_full   <= 1'b0;
        end else if (gen_v) begin
          out_q     <= gen;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (gen_v) begin
        sk_q    <= gen;
        sk_full <= 1'b1;
      end

      case (state)
        S_HDR: begin
          if (acc) begin
            cur_ch    <= hdr_ch;
            cur_tuser <= hdr_tuser;
            cur_taddr <= desc[11:0];
            quiet     <= 1'b0;
            res_data  <= s_axis_rc_tdata[DATA_W-1:96];
            res_keep  <= s_axis_rc_tkeep[KEEP_W-1:3];
            if (hdr_bad) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              if (!s_axis_rc_tlast) state <= S_DROP;
            end else if (!s_axis_rc_tlast) begin
              quiet <= dc_zero;
              state <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (acc) begin
            res_data <= s_axis_rc_tdata[DATA_W-1:96];
            res_keep <= s_axis_rc_tkeep[KEEP_W-1:3];
            if (s_axis_rc_tlast) state <= (!quiet && upper_keep) ? S_FLUSH : S_HDR;
          end
        end
        S_FLUSH: begin
          if (!sk_full) state <= S_HDR;
        end
        S_DROP: begin
          if (acc && s_axis_rc_tlast) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

  assign s_axis_rc_tready = in_rdy;
  assign m_axis_tvalid    = out_valid ? (NUM_CH'(1) << out_q.ch) : '0;
  assign m_axis_tdata     = out_q.data;
  assign m_axis_tkeep     = out_q.keep;
  assign m_axis_tlast     = out_q.last;
  assign m_axis_tuser     = out_q.tuser;
  assign m_axis_taddr     = out_q.taddr;
  assign dbg_state        = state;

endmodule

// File: tb/tb_rc_cpl_demux.sv
// Bench for rc_cpl_demux: directed scenarios plus randomized completions checked against a
// dword-stream reference model (drop 3 descriptor dwords, re-chunk into full-width beats).
module tb_rc_cpl_demux;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 16;
  localparam int NUM_CH = 6;
  localparam int CH_SEL_LSB = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [NUM_CH-1:0] vld;
    logic [15:0]       tuser;
    logic [11:0]       taddr;
  } beat_t;
  localparam int BEAT_W = $bits(beat_t);

  logic              user_clk, reset;
  logic              s_axis_rc_tvalid, s_axis_rc_tlast, s_axis_rc_tready;
  logic [DATA_W-1:0] s_axis_rc_tdata;
  logic [KEEP_W-1:0] s_axis_rc_tkeep;
  logic [16:0]       s_axis_rc_tuser;
  logic [NUM_CH-1:0] m_axis_tvalid, m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic [15:0]       m_axis_tuser, drop_cnt;
  logic [11:0]       m_axis_taddr;
  logic [1:0]        dbg_state;

  logic [BEAT_W-1:0] exp_q[$];
  int n_vec = 0, n_err = 0, n_fire = 0, low_cnt = 0, exp_drops = 0, cyc = 0, rdy_mode = 0;
  bit cnt_en = 0;
  logic [DATA_W-1:0] cpl_data[8];
  logic [KEEP_W-1:0] cpl_keep[8];

  rc_cpl_demux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_SEL_LSB(CH_SEL_LSB)) dut (
    .user_clk(user_clk), .reset(reset),
    .s_axis_rc_tvalid(s_axis_rc_tvalid), .s_axis_rc_tlast(s_axis_rc_tlast),
    .s_axis_rc_tdata(s_axis_rc_tdata), .s_axis_rc_tkeep(s_axis_rc_tkeep),
    .s_axis_rc_tuser(s_axis_rc_tuser), .s_axis_rc_tready(s_axis_rc_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_taddr(m_axis_taddr), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1);
  end

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- consumer ready ----------------
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge user_clk); #1;
      case (rdy_mode)
        0: m_axis_tready = '1;
        2: m_axis_tready = '0;
        default: for (int i = 0; i < NUM_CH; i++) m_axis_tready[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  beat_t prev_obs;
  bit    prev_stall = 0;
  always @(negedge user_clk) begin
    beat_t o;
    bit fire;
    if (cnt_en && !s_axis_rc_tready) low_cnt++;
    if (reset) begin
      prev_stall = 0;
    end else begin
      o.data = m_axis_tdata; o.keep = m_axis_tkeep; o.last = m_axis_tlast;
      o.vld = m_axis_tvalid; o.tuser = m_axis_tuser; o.taddr = m_axis_taddr;
      if (prev_stall) chk("hold_while_stalled", o, prev_obs);
      if (m_axis_tvalid != '0) chk_i("valid_onehot", $countones(m_axis_tvalid), 1);
      fire = |(m_axis_tvalid & m_axis_tready);
      if (fire) begin
        n_fire++;
        chk_i("beat_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("beat", o, exp_q.pop_front());
      end
      prev_stall = (m_axis_tvalid != '0) && !fire;
      prev_obs = o;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_cpl(input int n);
    logic [95:0] desc;
    logic [31:0] dw[$];
    logic        kb[$];
    beat_t b;
    int ch, last_j;
    bit err, tail_keep;
    desc = cpl_data[0][95:0];
    ch = int'(desc[71:64]) / 32;  // six channels -> 3-bit field at tag[7:5]
    err = 0;
`ifdef RC_ERR_DROP_EN
    err = (desc[45:43] != 3'd0) || (desc[15:12] != 4'd0);
`endif
    if (ch >= NUM_CH || err) begin
      exp_drops++;
      return;
    end
    b.vld = NUM_CH'(1) << ch;
    b.tuser = {desc[71:64], desc[46:43], desc[15:12]};
    b.taddr = desc[11:0];
    if (desc[42:32] == 11'd0) begin
      b.data = '0; b.keep = '0; b.last = 1'b1;
      exp_q.push_back(b);
      return;
    end
    for (int j = 0; j < n; j++)
      for (int i = 0; i < KEEP_W; i++) begin
        dw.push_back(cpl_data[j][i*32 +: 32]);
        kb.push_back(cpl_keep[j][i]);
      end
    repeat (3) begin void'(dw.pop_front()); void'(kb.pop_front()); end
    repeat (3) begin dw.push_back('0); kb.push_back(1'b0); end
    tail_keep = 0;
    for (int i = 0; i < KEEP_W; i++) tail_keep |= kb[16*(n-1) + i];
    last_j = (n > 1 && !tail_keep) ? n - 2 : n - 1;
    for (int j = 0; j <= last_j; j++) begin
      for (int i = 0; i < KEEP_W; i++) begin
        b.data[i*32 +: 32] = dw[16*j + i];
        b.keep[i] = kb[16*j + i];
      end
      b.last = (j == last_j);
      exp_q.push_back(b);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_cpl(input logic [7:0] tag, input logic [10:0] dc, input int n,
                         input logic [15:0] last_keep, input bit rnd);
    for (int i = 0; i < n; i++) begin
      cpl_data[i] = rand_data();
      cpl_keep[i] = rnd ? 16'($urandom) : 16'hFFFF;
    end
    if (!rnd) cpl_keep[n-1] = last_keep;
    cpl_data[0][11:0]  = 12'($urandom);
    cpl_data[0][15:12] = (rnd && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    cpl_data[0][42:32] = dc;
    cpl_data[0][46:43] = (rnd && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    cpl_data[0][71:64] = tag;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input bit last);
    int w;
    bit rdy;
    s_axis_rc_tvalid = 1'b1; s_axis_rc_tdata = d; s_axis_rc_tkeep = k; s_axis_rc_tlast = last;
    s_axis_rc_tuser = 17'($urandom);
    w = 0;
    forever begin
      @(negedge user_clk) rdy = s_axis_rc_tready;
      @(posedge user_clk); #1;
      if (rdy || w >= 1000) break;
      w++;
    end
    chk_i("accept_wait", int'(w < 1000), 1);
    s_axis_rc_tvalid = 1'b0; s_axis_rc_tlast = 1'b0;
  endtask

  task automatic send_cpl(input int n, input bit gaps);
    model_cpl(n);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge user_clk); #1; end
      drive_beat(cpl_data[i], cpl_keep[i], i == n - 1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid != '0) && w < 1000) begin
      @(posedge user_clk); #1;
      w++;
    end
    chk_i("drain", int'(w < 1000), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int f0, c0;
    reset = 1'b1; s_axis_rc_tvalid = 1'b0; s_axis_rc_tlast = 1'b0;
    s_axis_rc_tdata = '0; s_axis_rc_tkeep = '0; s_axis_rc_tuser = '0;
    repeat (4) @(posedge user_clk);
    @(negedge user_clk);
    chk_i("rst_tvalid", int'(m_axis_tvalid), 0);
    chk_i("rst_tready", int'(s_axis_rc_tready), 1);
    chk_i("rst_drop_cnt", int'(drop_cnt), 0);
    chk_i("rst_state", int'(dbg_state), 0);
    chk_i("rst_out", int'(m_axis_tlast) + int'(m_axis_tkeep) + int'(m_axis_tuser) + int'(|m_axis_tdata), 0);
    @(posedge user_clk); #1 reset = 1'b0;

    // single-beat completion: visible one cycle after acceptance
    set_cpl(8'h20, 11'd4, 1, 16'h007F, 0);
    send_cpl(1, 0);
    @(negedge user_clk);
    chk_i("lat_valid", int'(m_axis_tvalid), 2);
    chk_i("lat_keep", int'(m_axis_tkeep), 'h000F);
    chk_i("lat_tag", int'(m_axis_tuser[15:8]), 'h20);
    chk_i("lat_tlast", int'(m_axis_tlast), 1);
    drain();

    // 3 beats, residue empty on last beat: two outputs, no flush
    cnt_en = 1; low_cnt = 0; f0 = n_fire;
    set_cpl(8'h41, 11'd40, 3, 16'h0007, 0);
    send_cpl(3, 0); drain();
    chk_i("nof_beats", n_fire - f0, 2);
    chk_i("nof_tready_low", low_cnt, 0);

    // 3 beats with residue: flush beat, tready low one cycle
    low_cnt = 0; f0 = n_fire;
    set_cpl(8'h41, 11'd40, 3, 16'h00FF, 0);
    send_cpl(3, 0); drain();
    chk_i("flush_beats", n_fire - f0, 3);
    chk_i("flush_tready_low", low_cnt, 1);

    // unknown channel: consumed silently and counted
    low_cnt = 0; f0 = n_fire;
    set_cpl(8'hE0, 11'd40, 4, 16'hFFFF, 0);
    send_cpl(4, 0); drain();
    chk_i("drop_beats", n_fire - f0, 0);
    chk_i("drop_cnt_one", int'(drop_cnt), exp_drops);
    chk_i("drop_tready_low", low_cnt, 0);
    cnt_en = 0;

    // zero dword count
    f0 = n_fire;
    set_cpl(8'h60, 11'd0, 1, 16'hFFFF, 0);
    send_cpl(1, 0); drain();
    chk_i("dc0_beats", n_fire - f0, 1);

    // back-to-back: no bubble normally, one bubble after a flush
    set_cpl(8'h21, 11'd3, 1, 16'h003F, 0);
    c0 = cyc; send_cpl(1, 0);
    set_cpl(8'h82, 11'd3, 1, 16'h003F, 0);
    send_cpl(1, 0);
    chk_i("b2b_cycles", cyc - c0, 2);
    drain();
    set_cpl(8'h41, 11'd20, 2, 16'h00FF, 0);
    c0 = cyc; send_cpl(2, 0);
    set_cpl(8'h21, 11'd3, 1, 16'h003F, 0);
    send_cpl(1, 0);
    chk_i("flush_bubble_cycles", cyc - c0, 4);
    drain();

    // consumer stall mid-burst
    cnt_en = 1; low_cnt = 0;
    set_cpl(8'hA3, 11'd90, 6, 16'h0FFF, 0);
    fork
      send_cpl(6, 0);
      begin
        repeat (3) @(posedge user_clk);
        #2 rdy_mode = 2;
        repeat (5) @(posedge user_clk);
        #2 rdy_mode = 0;
      end
    join
    drain();
    cnt_en = 0;
    chk_i("stall_backpressure", int'(low_cnt > 0), 1);

    // reset in the middle of a completion
    set_cpl(8'h41, 11'd8, 3, 16'hFFFF, 0);
    drive_beat(cpl_data[0], cpl_keep[0], 1'b0);
    reset = 1'b1; exp_drops = 0;
    repeat (2) @(posedge user_clk);
    #1 reset = 1'b0;
    @(negedge user_clk);
    chk_i("midrst_tvalid", int'(m_axis_tvalid), 0);
    chk_i("midrst_state", int'(dbg_state), 0);
    chk_i("midrst_drop_cnt", int'(drop_cnt), 0);
    chk_i("midrst_tready", int'(s_axis_rc_tready), 1);
    @(posedge user_clk); #1;
    set_cpl(8'h22, 11'd20, 2, 16'h0003, 0);
    send_cpl(2, 0); drain();

    // randomized completions with random consumer backpressure
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 5);
      set_cpl(8'($urandom), ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047)), n, 16'h0, 1);
      send_cpl(n, 1);
    end
    drain();
    rdy_mode = 0;

    chk_i("final_drop_cnt", int'(drop_cnt), exp_drops);
    chk_i("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
